// File: rtl/mips_regfile_pkg.sv
// ============================================================================
//  Module      : mips_regfile_pkg
//  Description : Shared register-file and MIPS decode constants.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_regfile_pkg;

    localparam int c_data_w = 32;
    localparam int c_addr_w = 5;

    localparam logic [4:0] c_reg_zero = 5'd0;
    localparam logic [4:0] c_reg_ra   = 5'd31;

    // Primary opcodes and R-type function codes consumed by control
    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_ADDI  = 6'h08,
        OP_ANDI  = 6'h0C,
        OP_ORI   = 6'h0D,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B
    } opcode_e;

    typedef enum logic [5:0] {
        FN_ADD = 6'h20,
        FN_AND = 6'h24,
        FN_OR  = 6'h25
    } funct_e;

endpackage : mips_regfile_pkg

`default_nettype wire

// File: rtl/mips_regfile_reg32.sv
// ============================================================================
//  Module      : mips_regfile_reg32
//  Description : DATA_W-bit register with load enable and async active-low clear.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_regfile_reg32
    import mips_regfile_pkg::*;
#(
    parameter int DATA_W = c_data_w
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (ld) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule : mips_regfile_reg32

`default_nettype wire

// File: rtl/mips_regfile.sv
// ============================================================================
//  Module      : mips_regfile
//  Description : 32 x 32 MIPS register file, two async reads, one sync write.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_regfile
    import mips_regfile_pkg::*;
#(
    parameter int DATA_W = c_data_w,
    parameter int ADDR_W = c_addr_w
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    localparam int c_depth = 2 ** ADDR_W;

    // Mux inputs; entry 0 is a constant zero so $0 needs no storage.
    logic [DATA_W-1:0] w_regs [c_depth];

    assign w_regs[0] = '0;

    genvar gi;
    generate
        for (gi = 1; gi < c_depth; gi++) begin : g_reg
            localparam logic [ADDR_W-1:0] c_idx = ADDR_W'(gi);
            logic w_ld;

            // One decoder output, gated by the write strobe
            assign w_ld = wr_en & (wr_addr == c_idx);

            mips_regfile_reg32 #(
                .DATA_W (DATA_W)
            ) u_reg (
                .clk   (clk),
                .rst_n (rst_n),
                .ld    (w_ld),
                .d     (wr_data),
                .q     (w_regs[gi])
            );
        end
    endgenerate

    // No write-to-read bypass: reads see the old value until the edge.
    assign rd_data_a = w_regs[rd_addr_a];
    assign rd_data_b = w_regs[rd_addr_b];

endmodule : mips_regfile

`default_nettype wire
